// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate prescaler plus H/V raster counters with registered,
// mutually aligned sync, blanking and frame-start outputs.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          tick_d, h_wrap, hsync_d, vsync_d, video_d, fs_d;
    logic          tick_q, hsync_q, vsync_q, video_q, fs_q;

    // Decodes look at the next-state counters so they land on the same edge as the counters.
    always_comb begin
        tick_d  = div_q == DIV_MAX;
        div_d   = tick_d ? '0 : div_q + DW'(1);
        h_wrap  = tick_d && x_q == H_MAX;
        x_d     = !tick_d ? x_q : h_wrap ? 10'd0 : x_q + 10'd1;
        y_d     = !h_wrap ? y_q : (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
        hsync_d = !(x_d >= HS_FIRST && x_d <= HS_LAST);
        vsync_d = !(y_d >= VS_FIRST && y_d <= VS_LAST);
        video_d = x_d < H_DISP && y_d < V_DISP;
        fs_d    = h_wrap && y_q == V_MAX;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            tick_q  <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tick_q  <= tick_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            fs_q    <= fs_d;
        end
    end

    assign p_tick      = tick_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = video_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vectors plus a closed-form per-clock model for a
// default-sized and a tiny-raster instance sharing clock and reset.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       d_p, d_v, d_hs, d_vs, d_fs, s_p, s_v, s_hs, s_vs, s_fs;
    logic [9:0] d_x, d_y, s_x, s_y;

    vga_timing_gen dut_d (
        .clk(clk), .reset_n(reset_n), .p_tick(d_p), .pixel_x(d_x), .pixel_y(d_y),
        .video_on(d_v), .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .p_tick(s_p), .pixel_x(s_x), .pixel_y(s_y),
        .video_on(s_v), .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
    );

    typedef struct {int p; int x; int y; int v; int hs; int vs; int fs;} out_t;
    typedef struct {int n; out_t e;} vec_t;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int d_hs_low = 0;
    int s_vs_low = 0;
    int fs_at[$];
    vec_t tbl_d[$];
    vec_t tbl_s[$];

    localparam out_t RST = '{0, 0, 0, 0, 1, 1, 0};

    function automatic vec_t mk(int nn, int p, int x, int y, int v, int hs, int vs, int fs);
        vec_t r;
        r.n = nn;
        r.e = '{p, x, y, v, hs, vs, fs};
        return r;
    endfunction

    // Closed form: after n edges the raster has advanced n/cd pixels.
    function automatic out_t model(int nn, int cd, int hd, int hf, int hw, int hb,
                                   int vd, int vf, int vw, int vb);
        out_t r;
        int ht, vt, lin;
        if (nn == 0) return RST;
        ht  = hd + hf + hw + hb;
        vt  = vd + vf + vw + vb;
        lin = (nn / cd) % (ht * vt);
        r.p  = (nn % cd == 0) ? 1 : 0;
        r.x  = lin % ht;
        r.y  = lin / ht;
        r.v  = (r.x < hd && r.y < vd) ? 1 : 0;
        r.hs = (r.x >= hd + hf && r.x < hd + hf + hw) ? 0 : 1;
        r.vs = (r.y >= vd + vf && r.y < vd + vf + vw) ? 0 : 1;
        r.fs = (r.p == 1 && lin == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d actual=%0d expected=%0d", nm, n, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input out_t e, input logic p, input logic [9:0] x,
                           input logic [9:0] y, input logic v, input logic hs, input logic vs,
                           input logic fs);
        chk({tag, ".p_tick"}, {31'b0, p}, e.p);
        chk({tag, ".pixel_x"}, {22'b0, x}, e.x);
        chk({tag, ".pixel_y"}, {22'b0, y}, e.y);
        chk({tag, ".video_on"}, {31'b0, v}, e.v);
        chk({tag, ".hsync"}, {31'b0, hs}, e.hs);
        chk({tag, ".vsync"}, {31'b0, vs}, e.vs);
        chk({tag, ".frame_start"}, {31'b0, fs}, e.fs);
    endtask

    task automatic check_models();
        chk_out("d_model", model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33), d_p, d_x, d_y, d_v, d_hs, d_vs, d_fs);
        chk_out("s_model", model(n, 2, 8, 2, 3, 3, 4, 1, 1, 1), s_p, s_x, s_y, s_v, s_hs, s_vs, s_fs);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        check_models();
        if (n <= 3200 && !d_hs) d_hs_low++;
        if (n <= 224 && !s_vs) s_vs_low++;
        if (s_fs) fs_at.push_back(n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        d_hs_low = 0;
        s_vs_low = 0;
        fs_at.delete();
        check_models();
    endtask

    initial begin
        tbl_d.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        tbl_d.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0));
        tbl_d.push_back(mk(3, 0, 0, 0, 1, 1, 1, 0));
        tbl_d.push_back(mk(4, 1, 1, 0, 1, 1, 1, 0));
        tbl_d.push_back(mk(5, 0, 1, 0, 1, 1, 1, 0));
        tbl_d.push_back(mk(8, 1, 2, 0, 1, 1, 1, 0));
        tbl_d.push_back(mk(2556, 1, 639, 0, 1, 1, 1, 0));
        tbl_d.push_back(mk(2560, 1, 640, 0, 0, 1, 1, 0));
        tbl_d.push_back(mk(2623, 0, 655, 0, 0, 1, 1, 0));
        tbl_d.push_back(mk(2624, 1, 656, 0, 0, 0, 1, 0));
        tbl_d.push_back(mk(2627, 0, 656, 0, 0, 0, 1, 0));
        tbl_d.push_back(mk(3004, 1, 751, 0, 0, 0, 1, 0));
        tbl_d.push_back(mk(3008, 1, 752, 0, 0, 1, 1, 0));
        tbl_d.push_back(mk(3196, 1, 799, 0, 0, 1, 1, 0));
        tbl_d.push_back(mk(3200, 1, 0, 1, 1, 1, 1, 0));
        tbl_d.push_back(mk(3201, 0, 0, 1, 1, 1, 1, 0));

        tbl_s.push_back(mk(2, 1, 1, 0, 1, 1, 1, 0));
        tbl_s.push_back(mk(20, 1, 10, 0, 0, 0, 1, 0));
        tbl_s.push_back(mk(26, 1, 13, 0, 0, 1, 1, 0));
        tbl_s.push_back(mk(32, 1, 0, 1, 1, 1, 1, 0));
        tbl_s.push_back(mk(160, 1, 0, 5, 0, 1, 0, 0));
        tbl_s.push_back(mk(192, 1, 0, 6, 0, 1, 1, 0));
        tbl_s.push_back(mk(222, 1, 15, 6, 0, 1, 1, 0));
        tbl_s.push_back(mk(224, 1, 0, 0, 1, 1, 1, 1));
        tbl_s.push_back(mk(225, 0, 0, 0, 1, 1, 1, 0));

        // Default raster: first line, table plus per-clock model.
        do_reset();
        foreach (tbl_d[i]) begin
            while (n < tbl_d[i].n) step();
            chk_out("d_vec", tbl_d[i].e, d_p, d_x, d_y, d_v, d_hs, d_vs, d_fs);
        end
        chk("d_hsync_low_clks", d_hs_low, 384);

        // Tiny raster: whole frames and frame_start period.
        do_reset();
        foreach (tbl_s[i]) begin
            while (n < tbl_s[i].n) step();
            chk_out("s_vec", tbl_s[i].e, s_p, s_x, s_y, s_v, s_hs, s_vs, s_fs);
        end
        while (n < 450) step();
        chk("s_vsync_low_clks", s_vs_low, 32);
        chk("s_fs_count", fs_at.size(), 2);
        if (fs_at.size() >= 2) begin
            chk("s_fs_first", fs_at[0], 224);
            chk("s_fs_period", fs_at[1] - fs_at[0], 224);
        end

        // Async reset mid-frame while both syncs of the tiny raster are low.
        do_reset();
        while (n < 182) step();
        chk_out("s_pre_rst", '{1, 11, 5, 0, 0, 0, 0}, s_p, s_x, s_y, s_v, s_hs, s_vs, s_fs);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("d_async_rst", RST, d_p, d_x, d_y, d_v, d_hs, d_vs, d_fs);
        chk_out("s_async_rst", RST, s_p, s_x, s_y, s_v, s_hs, s_vs, s_fs);
        repeat (2) @(negedge clk);
        chk_out("s_rst_held", RST, s_p, s_x, s_y, s_v, s_hs, s_vs, s_fs);
        reset_n = 1'b1;
        n = 0;
        check_models();
        while (n < 4) step();
        chk_out("d_restart", '{1, 1, 0, 1, 1, 1, 0}, d_p, d_x, d_y, d_v, d_hs, d_vs, d_fs);
        chk_out("s_restart", '{1, 2, 0, 1, 1, 1, 0}, s_p, s_x, s_y, s_v, s_hs, s_vs, s_fs);
        while (n < 240) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
